tdm_demux: RTL and testbench
============================

// Module: tdm_demux
// PURPOSE
//  Time-division demultiplexer: the receive end of our mux-based TDM link. One shared
//  W-bit lane carries N_CH channels in fixed slot order. fsync marks slot 0.
//  The block tracks the slot position and routes each sample to its channel register.
//  It publishes a complete frame in parallel on dout with a 1-cycle dout_valid pulse.
//  It also flags framing errors. Sits between the serial link and per-channel consumers.
// PARAMETERS
//  N_CH  4  channels per frame (>=2); slot counter width SW = $clog2(N_CH)
//  W     1  bits per sample/channel
// PORTS
//  clk        in   1        system clock, all state on rising edge
//  rst        in   1        asynchronous reset, active-high
//  din        in   W        TDM sample
//  din_valid  in   1        din (and fsync) valid this cycle; low = lane idle, no advance
//  fsync      in   1        with din_valid: this sample is slot 0 (channel 0)
//  dout       out  N_CH*W   last complete frame; channel k at dout[k*W +: W]
//  dout_valid out  1        1-cycle pulse: dout updated this cycle
//  locked     out  1        1 = frame alignment held (state LOCKED)
//  frame_err  out  1        1-cycle pulse: framing violation detected
// BEHAVIOUR
//  Reset (async, any time): state=HUNT, slot=0, staging=0, dout=0,
//   dout_valid=0, locked=0, frame_err=0. A partial frame is discarded, never published.
//  Accept = din_valid=1 on a rising edge. fsync and din are ignored when din_valid=0.
//   Slot, staging and state are held when din_valid=0. Idle gaps of any length are legal.
//  FSM states: HUNT and LOCKED. locked is a registered copy of (state==LOCKED).
//  HUNT:
//   - accept with fsync=1: store din to staging[0], slot<=1, go to LOCKED.
//   - accept with fsync=0: drop the sample, stay in HUNT. frame_err is NOT asserted.
//  LOCKED, accept at slot s:
//   - 0<s<N_CH-1, fsync=0: staging[s]<=din, slot<=s+1.
//   - s=N_CH-1, fsync=0: dout<={din,staging[N_CH-2:0]}, dout_valid<=1, slot<=0.
//   - s=0, fsync=1: staging[0]<=din, slot<=1 (normal frame start).
//   - s!=0, fsync=1 (early sync): frame_err<=1, discard the partial frame, no dout_valid.
//     Resync on this sample: staging[0]<=din, slot<=1, stay in LOCKED.
//   - s=0, fsync=0 (missing sync): frame_err<=1, drop the sample, slot<=0, go to HUNT.
//  Latency: dout/dout_valid are registered. They appear the cycle after the edge that
//   accepts slot N_CH-1. dout holds its value until the next complete frame.
//  Pulses: dout_valid and frame_err are high for exactly one cycle per event.
//   With back-to-back frames they never merge. dout_valid and frame_err are never high
//   in the same cycle. Slot wrap N_CH-1 -> 0 happens only on a completed frame.
//  staging is internal only and never visible on dout.
// TESTING (N_CH=4, W=1)
//  1 reset; accepts fsync=1 din=1, then din=0,1,1 back-to-back
//    -> locked=1 after 1st edge; dout=4'b1101, dout_valid=1 one cycle after 4th accept.
//  2 same frame with 3 idle cycles between each sample -> identical dout=4'b1101.
//    Exactly one dout_valid pulse; slot does not advance during idle cycles.
//  3 continuous valid, 3 frames (fsync every 4th) with data 1000,0110,1111 (ch0 first)
//    -> dout_valid every 4 cycles; dout = 4'b0001, 4'b0110, 4'b1111.
//  4 locked; slots 0,1 accepted, then fsync=1 at slot 2 with din=0, then 3 more samples 1,1,1
//    -> frame_err pulse, no dout_valid for the partial frame, locked stays 1; next dout=4'b1110.
//  5 locked; complete frame, then accept with fsync=0
//    -> frame_err pulse, locked=0. Further fsync=0 samples dropped, no frame_err.
//    Next fsync reacquires lock.
//  6 assert rst asynchronously after slot 2 of a frame, release, send a full frame 0011
//    -> all outputs 0 immediately on rst, no stale data published; then dout=4'b1100.

Source files
------------

// File: rtl/tdm_demux.sv
// Receive end of the TDM link: tracks slot position on a shared W-bit lane and
// publishes each complete N_CH-channel frame in parallel, flagging framing errors.
module tdm_demux #(
  parameter int N_CH = 4,
  parameter int W    = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [W-1:0]        din,
  input  logic                din_valid,
  input  logic                fsync,
  output logic [N_CH*W-1:0]   dout,
  output logic                dout_valid,
  output logic                locked,
  output logic                frame_err
);

  localparam int SW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [SW-1:0] LAST_SLOT = SW'(N_CH - 1);
  localparam logic [SW-1:0] SLOT_ONE  = SW'(1);

  localparam logic [0:0] HUNT   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]        state;
  logic [SW-1:0]     slot;
  logic [N_CH*W-1:0] staging;

  // Accept stage: slot tracking, staging and frame publish in one registered step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= HUNT;
      slot       <= '0;
      staging    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      locked     <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (din_valid) begin
        if (state == HUNT) begin
          if (fsync) begin
            staging[W-1:0] <= din;
            slot           <= SLOT_ONE;
            state          <= LOCKED;
            locked         <= 1'b1;
          end
        end else if (fsync) begin
          // An early sync abandons the partial frame and restarts on this sample
          if (slot != '0)
            frame_err <= 1'b1;
          staging[W-1:0] <= din;
          slot           <= SLOT_ONE;
        end else if (slot == '0) begin
          frame_err <= 1'b1;
          state     <= HUNT;
          locked    <= 1'b0;
        end else if (slot == LAST_SLOT) begin
          dout       <= {din, staging[(N_CH-1)*W-1:0]};
          dout_valid <= 1'b1;
          slot       <= '0;
        end else begin
          for (int k = 1; k < N_CH - 1; k++) begin
            if (slot == SW'(k))
              staging[k*W +: W] <= din;
          end
          slot <= slot + SLOT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux (N_CH=4, W=1): lock, idle gaps, back-to-back
// frames, early sync, missing sync and asynchronous reset mid-frame.
module tb_tdm_demux;

  localparam int N_CH = 4;
  localparam int W    = 1;

  logic              clk;
  logic              rst;
  logic [W-1:0]      din;
  logic              din_valid;
  logic              fsync;
  logic [N_CH*W-1:0] dout;
  logic              dout_valid;
  logic              locked;
  logic              frame_err;

  int total;
  int bad;
  int dv_cnt;
  int fe_cnt;
  int both_total;
  int both_bad;

  tdm_demux #(.N_CH(N_CH), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .fsync      (fsync),
    .dout       (dout),
    .dout_valid (dout_valid),
    .locked     (locked),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters and the never-together rule, sampled mid-cycle
  always @(negedge clk) begin
    if (dout_valid === 1'b1) dv_cnt++;
    if (frame_err === 1'b1) fe_cnt++;
    if (dout_valid === 1'b1 || frame_err === 1'b1) begin
      both_total++;
      if (dout_valid === 1'b1 && frame_err === 1'b1) begin
        both_bad++;
        $display("FAIL pulse_overlap dout_valid=%b frame_err=%b required not both 1", dout_valid, frame_err);
      end
    end
  end

  task automatic accept(input logic fs, input logic d);
    din_valid = 1'b1;
    fsync     = fs;
    din       = d;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    fsync     = 1'b1;
    din       = 1'b1;
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    fsync     = 1'b1;
    din       = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    total++;
    if (dout !== 4'b0000 || dout_valid !== 1'b0 || locked !== 1'b0 || frame_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs got dout=%b dv=%b lk=%b fe=%b required all 0", dout, dout_valid, locked, frame_err);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_lock_frame();
    accept(1'b1, 1'b1);
    total++;
    if (locked !== 1'b1 || dout_valid !== 1'b0) begin
      bad++;
      $display("FAIL t1_lock got lk=%b dv=%b required lk=1 dv=0", locked, dout_valid);
    end
    accept(1'b0, 1'b0);
    accept(1'b0, 1'b1);
    total++;
    if (dout_valid !== 1'b0) begin
      bad++;
      $display("FAIL t1_early_dv got=%b required=0", dout_valid);
    end
    accept(1'b0, 1'b1);
    total++;
    if (dout_valid !== 1'b1 || dout !== 4'b1101) begin
      bad++;
      $display("FAIL t1_frame got dv=%b dout=%b required dv=1 dout=1101", dout_valid, dout);
    end
    idle(1);
    total++;
    if (dout_valid !== 1'b0 || dout !== 4'b1101) begin
      bad++;
      $display("FAIL t1_hold got dv=%b dout=%b required dv=0 dout=1101", dout_valid, dout);
    end
  endtask

  task automatic test_idle_gaps();
    int dv0;
    dv0 = dv_cnt;
    accept(1'b1, 1'b1);
    idle(3);
    accept(1'b0, 1'b0);
    idle(3);
    accept(1'b0, 1'b1);
    idle(3);
    total++;
    if (dv_cnt - dv0 !== 0 || locked !== 1'b1) begin
      bad++;
      $display("FAIL t2_no_advance got pulses=%0d lk=%b required pulses=0 lk=1", dv_cnt - dv0, locked);
    end
    accept(1'b0, 1'b1);
    total++;
    if (dout_valid !== 1'b1 || dout !== 4'b1101) begin
      bad++;
      $display("FAIL t2_frame got dv=%b dout=%b required dv=1 dout=1101", dout_valid, dout);
    end
    idle(3);
    total++;
    if (dv_cnt - dv0 !== 1) begin
      bad++;
      $display("FAIL t2_pulse_count got=%0d required=1", dv_cnt - dv0);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] frames [3];
    logic [3:0] f;
    int dv0;
    frames[0] = 4'b0001;
    frames[1] = 4'b0110;
    frames[2] = 4'b1111;
    dv0 = dv_cnt;
    for (int i = 0; i < 3; i++) begin
      f = frames[i];
      for (int k = 0; k < 4; k++) begin
        accept(k == 0, f[k]);
        if (k == 0 && i > 0) begin
          total++;
          if (dout_valid !== 1'b0) begin
            bad++;
            $display("FAIL t3_merge frame=%0d got dv=%b required=0", i, dout_valid);
          end
        end
      end
      total++;
      if (dout_valid !== 1'b1 || dout !== f) begin
        bad++;
        $display("FAIL t3_frame%0d got dv=%b dout=%b required dv=1 dout=%b", i, dout_valid, dout, f);
      end
    end
    idle(1);
    total++;
    if (dv_cnt - dv0 !== 3) begin
      bad++;
      $display("FAIL t3_pulse_count got=%0d required=3", dv_cnt - dv0);
    end
  endtask

  task automatic test_early_sync();
    int dv0;
    dv0 = dv_cnt;
    accept(1'b1, 1'b1);
    accept(1'b0, 1'b1);
    accept(1'b1, 1'b0);
    total++;
    if (frame_err !== 1'b1 || locked !== 1'b1 || dout_valid !== 1'b0) begin
      bad++;
      $display("FAIL t4_err got fe=%b lk=%b dv=%b required fe=1 lk=1 dv=0", frame_err, locked, dout_valid);
    end
    accept(1'b0, 1'b1);
    total++;
    if (frame_err !== 1'b0) begin
      bad++;
      $display("FAIL t4_err_width got fe=%b required=0", frame_err);
    end
    accept(1'b0, 1'b1);
    accept(1'b0, 1'b1);
    total++;
    if (dout_valid !== 1'b1 || dout !== 4'b1110 || dv_cnt - dv0 !== 0) begin
      bad++;
      $display("FAIL t4_resync got dv=%b dout=%b prior=%0d required dv=1 dout=1110 prior=0", dout_valid, dout, dv_cnt - dv0);
    end
    idle(1);
  endtask

  task automatic test_missing_sync();
    int fe0;
    accept(1'b1, 1'b0);
    accept(1'b0, 1'b1);
    accept(1'b0, 1'b0);
    accept(1'b0, 1'b1);
    total++;
    if (dout_valid !== 1'b1 || dout !== 4'b1010) begin
      bad++;
      $display("FAIL t5_frame got dv=%b dout=%b required dv=1 dout=1010", dout_valid, dout);
    end
    fe0 = fe_cnt;
    accept(1'b0, 1'b1);
    total++;
    if (frame_err !== 1'b1 || locked !== 1'b0) begin
      bad++;
      $display("FAIL t5_lost got fe=%b lk=%b required fe=1 lk=0", frame_err, locked);
    end
    accept(1'b0, 1'b1);
    accept(1'b0, 1'b0);
    total++;
    if (frame_err !== 1'b0 || locked !== 1'b0 || fe_cnt - fe0 !== 1) begin
      bad++;
      $display("FAIL t5_hunt got fe=%b lk=%b errs=%0d required fe=0 lk=0 errs=1", frame_err, locked, fe_cnt - fe0);
    end
    accept(1'b1, 1'b1);
    total++;
    if (locked !== 1'b1 || frame_err !== 1'b0) begin
      bad++;
      $display("FAIL t5_relock got lk=%b fe=%b required lk=1 fe=0", locked, frame_err);
    end
    accept(1'b0, 1'b0);
    accept(1'b0, 1'b0);
    accept(1'b0, 1'b1);
    total++;
    if (dout_valid !== 1'b1 || dout !== 4'b1001) begin
      bad++;
      $display("FAIL t5_after got dv=%b dout=%b required dv=1 dout=1001", dout_valid, dout);
    end
    idle(1);
  endtask

  task automatic test_async_reset();
    int dv0;
    accept(1'b1, 1'b1);
    accept(1'b0, 1'b1);
    accept(1'b0, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (dout !== 4'b0000 || dout_valid !== 1'b0 || locked !== 1'b0 || frame_err !== 1'b0) begin
      bad++;
      $display("FAIL t6_async got dout=%b dv=%b lk=%b fe=%b required all 0", dout, dout_valid, locked, frame_err);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    dv0 = dv_cnt;
    accept(1'b0, 1'b1);
    total++;
    if (dout_valid !== 1'b0 || locked !== 1'b0 || frame_err !== 1'b0) begin
      bad++;
      $display("FAIL t6_stale got dv=%b lk=%b fe=%b required all 0", dout_valid, locked, frame_err);
    end
    accept(1'b1, 1'b0);
    accept(1'b0, 1'b0);
    accept(1'b0, 1'b1);
    total++;
    if (dout_valid !== 1'b0 || dv_cnt - dv0 !== 0) begin
      bad++;
      $display("FAIL t6_partial got dv=%b pulses=%0d required dv=0 pulses=0", dout_valid, dv_cnt - dv0);
    end
    accept(1'b0, 1'b1);
    total++;
    if (dout_valid !== 1'b1 || dout !== 4'b1100) begin
      bad++;
      $display("FAIL t6_frame got dv=%b dout=%b required dv=1 dout=1100", dout_valid, dout);
    end
    idle(2);
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    dv_cnt     = 0;
    fe_cnt     = 0;
    both_total = 0;
    both_bad   = 0;
    rst        = 1'b0;
    din        = '0;
    din_valid  = 1'b0;
    fsync      = 1'b0;
    #2;
    test_reset();
    test_lock_frame();
    test_idle_gaps();
    test_back_to_back();
    test_early_sync();
    test_missing_sync();
    test_async_reset();
    total = total + both_total;
    bad   = bad + both_bad;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
